// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction fetch front end.
//   seq_state_e    : fetch sequencer FSM states (idle, fetch, hold)
//   DefaultResetPc : default first fetch address after reset
//   PcWidth, ImmWidth, JumpWidth : address and immediate field widths
package mips_pkg;

  localparam int unsigned PcWidth   = 32;
  localparam int unsigned ImmWidth  = 16;
  localparam int unsigned JumpWidth = 26;

  localparam logic [PcWidth-1:0] DefaultResetPc = 32'h0040_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } seq_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational conditional-branch target.
//   pc_plus4      in  : address of the instruction after the branch
//   branch_imm    in  : raw 16-bit word offset from the instruction
//   branch_target out : pc_plus4 + (sign_extend(branch_imm) << 2), wrapping
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [PcWidth-1:0]  pc_plus4,
  input  logic [ImmWidth-1:0] branch_imm,
  output logic [PcWidth-1:0]  branch_target
);

  logic [PcWidth-1:0] offset;

  // Sign-extend and scale to a byte offset in one concatenation.
  always_comb begin
    offset = {{(PcWidth - ImmWidth - 2){branch_imm[ImmWidth-1]}}, branch_imm, 2'b00};
  end

  assign branch_target = pc_plus4 + offset;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetches one instruction at a time from instruction memory,
// holds it for decode, and computes the next PC from the decode result.
//   clk, reset               : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  : single-outstanding fetch handshake
//   instr, instr_valid       : registered instruction to decode
//   instr_ready              : decode accepts instr
//   branch_*, jump_*         : redirect decode, sampled on the transfer cycle
//   pc                       : address of the current or last fetch
// Build option: define BRANCH_DELAY_SLOT_EN to give redirects one delay slot.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC = DefaultResetPc
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [PcWidth-1:0]   imem_addr,
  input  logic                 imem_ack,
  input  logic [PcWidth-1:0]   imem_rdata,
  output logic [PcWidth-1:0]   instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch_valid,
  input  logic                 branch_taken,
  input  logic [ImmWidth-1:0]  branch_imm,
  input  logic                 jump_valid,
  input  logic [JumpWidth-1:0] jump_target,
  output logic [PcWidth-1:0]   pc
);

  seq_state_e         state_q, state_d;
  logic [PcWidth-1:0] pc_q, pc_d;
  logic [PcWidth-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               imem_req_q, imem_req_d;

  logic [PcWidth-1:0] pc_plus4;
  logic [PcWidth-1:0] branch_addr;
  logic [PcWidth-1:0] jump_addr;
  logic [PcWidth-1:0] redirect_addr;
  logic               redirect;
  logic               fetch_done;
  logic               xfer;

`ifdef BRANCH_DELAY_SLOT_EN
  logic               pend_valid_q, pend_valid_d;
  logic [PcWidth-1:0] pend_addr_q, pend_addr_d;
`endif

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_addr     = {pc_plus4[PcWidth-1:PcWidth-4], jump_target, 2'b00};
  assign redirect      = jump_valid | (branch_valid & branch_taken);
  // Jump has priority over a simultaneous branch.
  assign redirect_addr = jump_valid ? jump_addr : branch_addr;
  assign fetch_done    = imem_req_q & imem_ack;
  assign xfer          = instr_valid_q & instr_ready;

  branch_target_calc u_branch_target_calc (
    .pc_plus4      (pc_plus4),
    .branch_imm    (branch_imm),
    .branch_target (branch_addr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
`endif
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (fetch_done) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (xfer) begin
          instr_valid_d = 1'b0;
          state_d       = StFetch;
`ifdef BRANCH_DELAY_SLOT_EN
          // The accepted instruction is in a delay slot: its own redirect is dropped.
          if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
            if (redirect) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = redirect_addr;
            end
          end
`else
          pc_d = redirect ? redirect_addr : pc_plus4;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    imem_req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. The driver applies
// inputs on the falling edge and pushes expected fetch addresses and fetched
// words; a separate monitor pops and compares on each fetch and transfer.
// Honours BRANCH_DELAY_SLOT_EN in the reference model and directed constants.
module tb_pc_sequencer;

  localparam logic [31:0] ResetPc = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump_valid;
  logic [25:0] jump_target;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .pc           (pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model consumes the same inputs.
  task automatic cyc(input logic ack, input logic [31:0] rd, input logic rdy,
                     input logic bv, input logic bt, input logic [15:0] imm,
                     input logic jv, input logic [25:0] jt, input logic rst);
    logic [31:0] pc4, tgt, nxt;
    int          off;
    logic        redir;
    @(negedge clk);
    reset = rst; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
    branch_valid = bv; branch_taken = bt; branch_imm = imm;
    jump_valid = jv; jump_target = jt;
    if (rst) begin
      exp_addr_q.delete();
      exp_instr_q.delete();
      pend_q.delete();
      model_pc = ResetPc;
      exp_addr_q.push_back(ResetPc);
    end else begin
      if (imem_req === 1'b1 && ack) exp_instr_q.push_back(rd);
      if (instr_valid === 1'b1 && rdy) begin
        pc4   = model_pc + 32'd4;
        off   = $signed(imm);
        redir = jv || (bv && bt);
        if (jv) tgt = {pc4[31:28], jt, 2'b00};
        else    tgt = pc4 + 32'(off * 4);
`ifdef BRANCH_DELAY_SLOT_EN
        if (pend_q.size() > 0) begin
          nxt = pend_q.pop_front();
        end else begin
          if (redir) pend_q.push_back(tgt);
          nxt = pc4;
        end
`else
        nxt = redir ? tgt : pc4;
`endif
        model_pc = nxt;
        exp_addr_q.push_back(nxt);
      end
    end
  endtask

  // Quiet cycle: no ack, no ready, junk on the decode inputs.
  task automatic idle();
    cyc(1'b0, $urandom, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom),
        1'($urandom), 26'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
    cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, ResetPc);
    idle();
    chk("idle_req", 32'(imem_req), 32'd0);
    idle();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, ResetPc);
  endtask

  task automatic fetch_xfer(input logic [31:0] data, input logic bv, input logic bt,
                            input logic [15:0] imm, input logic jv, input logic [25:0] jt,
                            output logic [31:0] addr);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin idle(); n++; end
    chk("req_seen", 32'(imem_req), 32'd1);
    addr = imem_addr;
    cyc(1'b1, data, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin idle(); n++; end
    chk("valid_seen", 32'(instr_valid), 32'd1);
    cyc(1'b0, $urandom, 1'b1, bv, bt, imm, jv, jt, 1'b0);
  endtask

  // Monitor: compares whenever the DUT completes a fetch or a transfer.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (reset === 1'b0) begin
      if (imem_req === 1'b1 && imem_ack === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: got %h expected none", imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr, e);
          chk("pc_out", pc, e);
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (exp_instr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer_unexpected: got %h expected none", instr);
        end else begin
          e = exp_instr_q.pop_front();
          chk("xfer_instr", instr, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          n;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_taken = 1'b0; branch_imm = '0;
    jump_valid = 1'b0; jump_target = '0;

    // Taken branch at the reset PC, imm 3.
    do_reset();
    fetch_xfer(32'h1111_0001, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, a);
    chk("a_addr0", a, 32'h0040_0000);
`ifdef BRANCH_DELAY_SLOT_EN
    // Redirect in the delay slot is ignored.
    fetch_xfer(32'h1111_0002, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF, a);
    chk("a_slot", a, 32'h0040_0004);
`endif
    fetch_xfer(32'h1111_0003, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    chk("a_target", a, 32'h0040_0010);

    // Jump and branch together at 0x00400004: jump wins.
    do_reset();
    fetch_xfer(32'h2222_0001, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    fetch_xfer(32'h2222_0002, 1'b1, 1'b1, 16'h0005, 1'b1, 26'h010_0010, a);
    chk("b_addr1", a, 32'h0040_0004);
`ifdef BRANCH_DELAY_SLOT_EN
    fetch_xfer(32'h2222_0003, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    chk("b_slot", a, 32'h0040_0008);
`endif
    fetch_xfer(32'h2222_0004, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    chk("b_jump", a, 32'h0040_0040);

    // Not-taken branch, then backward branch imm -1 at 0x00400008.
    do_reset();
    fetch_xfer(32'h3333_0001, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    fetch_xfer(32'h3333_0002, 1'b1, 1'b0, 16'h0003, 1'b0, 26'h0, a);
    fetch_xfer(32'h3333_0003, 1'b1, 1'b1, 16'hFFFF, 1'b0, 26'h0, a);
    chk("c_addr2", a, 32'h0040_0008);
`ifdef BRANCH_DELAY_SLOT_EN
    fetch_xfer(32'h3333_0004, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    chk("c_slot", a, 32'h0040_000C);
`endif
    fetch_xfer(32'h3333_0005, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, a);
    chk("c_back", a, 32'h0040_0008);

    // Decode stall for 5 cycles, then reset in the middle of a fetch.
    do_reset();
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1, 26'($urandom), 1'b0);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin idle(); n++; end
    chk("d_req", 32'(imem_req), 32'd1);
    chk("d_addr", imem_addr, 32'h0040_0004);
    cyc(1'b1, 32'hBAD0_0BAD, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_pc", pc, ResetPc);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_instr", instr, 32'h0);
    idle();
    idle();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, ResetPc);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 6),
          1'($urandom), 1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
          26'($urandom), ($urandom_range(0, 199) == 0));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  fetch address; equals pc.
REQ-006 Port: imem_ack  input  1  memory has accepted the request and returned data; ignored unless imem_req=1.
REQ-007 Port: imem_rdata  input  32  fetched word; valid when imem_ack=1.
REQ-008 Port: instr  output  32  registered instruction presented to decode.
REQ-009 Port: instr_valid  output  1  instr holds a valid instruction.
REQ-010 Port: instr_ready  input  1  decode accepts instr; transfer occurs when instr_valid=1 and instr_ready=1.
REQ-011 Port: branch_valid, branch_taken  input  1 each  conditional-branch decode of the accepted instruction.
REQ-012 Port: branch_imm  input  16  raw branch immediate.
REQ-013 Port: jump_valid  input  1  J-type decode of the accepted instruction.
REQ-014 Port: jump_target  input  26  J-type target field.
REQ-015 Port: pc  output  32  address of the current or last fetch.

Function
REQ-016 FSM states: IDLE, FETCH, HOLD.
REQ-017 IDLE lasts exactly one cycle after reset deassertion, then transitions to FETCH.
REQ-018 FETCH: imem_req=1 and imem_addr stable until imem_ack; on ack, imem_rdata is registered into instr, instr_valid=1 next cycle (1-cycle latency), state -> HOLD.
REQ-019 HOLD: instr and instr_valid held until transfer; on transfer, pc is updated to next PC, instr_valid=0, state -> FETCH the following cycle.
REQ-020 branch_*/jump_* inputs are sampled only in the transfer cycle and ignored otherwise.
REQ-021 Next PC default: pc+4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
REQ-022 Taken branch target: pc+4 + (sign_extend(branch_imm) << 2), 32-bit, modulo 2^32.
REQ-023 Jump target: {pc_plus4[31:28], jump_target, 2'b00}.
REQ-024 If jump_valid and branch_valid are both 1, the jump wins.
REQ-025 branch_valid=1 with branch_taken=0 selects pc+4.
REQ-026 An imem_ack arriving in the same cycle as reset is discarded.

Reset
REQ-027 On reset: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, pending redirect cleared.
REQ-028 Reset asserted mid-FETCH or mid-HOLD aborts the operation; imem_req=0 and instr_valid=0 from the next cycle.

Configuration
REQ-029 Macro BRANCH_DELAY_SLOT_EN.
REQ-030 Defined: a redirect (taken branch or jump) is stored in a pending register; the next fetch is pc+4 (delay slot) and the fetch after that is the stored target.
REQ-031 Defined: a redirect decoded while a redirect is already pending (i.e. in the delay slot) is ignored.
REQ-032 Not defined: a redirect applies immediately to the next fetch; no pending register is present.

Structure
REQ-033 Shared package mips_pkg holds the FSM state enum, the RESET_PC default and the PC/immediate width constants.
REQ-034 One sub-module, branch_target_calc: combinational sign-extend, shift-left-2 and add.

Verification
REQ-035 Reset release, imem_ack 1 cycle after each req -> first imem_addr=32'h0040_0000, then 32'h0040_0004.
REQ-036 Taken branch at pc=32'h0040_0000 with imm=16'h0003 (no delay slot) -> next imem_addr=32'h0040_0010.
REQ-037 Taken branch at pc=32'h0040_0008 with imm=16'hFFFF -> next imem_addr=32'h0040_0008.
REQ-038 Jump and branch together at pc=32'h0040_0004, jump_target=26'h010_0010 -> next imem_addr=32'h0040_0040.
REQ-039 BRANCH_DELAY_SLOT_EN defined, branch at pc=32'h0040_0000 with imm=16'h0003 -> fetches 32'h0040_0004, then 32'h0040_0010.
REQ-040 instr_ready held 0 for 5 cycles -> instr stable and no imem_req; reset asserted mid-FETCH -> imem_req=0 next cycle and pc=RESET_PC.
